coincidence_trigger_engine: RTL and testbench

Parametrised trigger-decision engine for the trigger distribution board, sitting between the LVDS/coax trigger inputs and the coax trigger outputs. It stretches up to NCH masked inputs and arranges them as NLAYER layers × NCOL columns. It evaluates one run-time-selected trigger mode (any-hit, multiplicity, M-of-L layer coincidence or rolling) under prescale, busy veto and deadtime. It drives programmable-width output pulses and presents a timestamped event record over a valid/ready handshake.

---
 rtl/trig_pkg.sv | 38 +++
 rtl/coincidence_trigger_engine_if.sv | 35 +++
 rtl/trig_stretch.sv | 47 ++++
 rtl/coincidence_trigger_engine.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_coincidence_trigger_engine.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trig_pkg.sv
// -----------------------------------------------------------------------------
// trig_pkg
// Shared definitions for the coincidence trigger engine:
//   - trig_mode_e : run-time trigger mode encoding (values 5..7 behave as OFF)
//   - DEF_*       : default parameter values for the engine
//   - sat_inc16   : saturating 16-bit increment used by the lost-event counter
// -----------------------------------------------------------------------------
package trig_pkg;

  typedef enum logic [2:0] {
    OFF  = 3'd0,
    ANY  = 3'd1,
    MULT = 3'd2,
    COIN = 3'd3,
    ROLL = 3'd4
  } trig_mode_e;

  localparam int DEF_NCH    = 64;
  localparam int DEF_NLAYER = 4;
  localparam int DEF_NOUT   = 16;
  localparam int DEF_SW     = 6;
  localparam int DEF_DTW    = 8;
  localparam int DEF_TSW    = 56;

  localparam logic [15:0] LOST_MAX = 16'hFFFF;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == LOST_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/coincidence_trigger_engine_if.sv
// -----------------------------------------------------------------------------
// coincidence_trigger_engine_if
// Event-record channel of the trigger engine (valid/ready handshake).
//   evt_valid : record available               (master -> slave)
//   evt_ready : consumer accepts the record     (slave  -> master)
//   evt_ts    : TSW-bit timestamp of the fire   (master -> slave)
//   evt_mode  : mode that fired                 (master -> slave)
//   evt_cols  : column-active mask at the fire  (master -> slave)
//   evt_lost  : saturating dropped-fire count   (master -> slave)
// -----------------------------------------------------------------------------
interface coincidence_trigger_engine_if
  import trig_pkg::*;
#(
  parameter int NCOL = DEF_NCH / DEF_NLAYER,
  parameter int TSW  = DEF_TSW
);

  logic            evt_valid;
  logic            evt_ready;
  logic [TSW-1:0]  evt_ts;
  logic [2:0]      evt_mode;
  logic [NCOL-1:0] evt_cols;
  logic [15:0]     evt_lost;

  modport master (
    output evt_valid, evt_ts, evt_mode, evt_cols, evt_lost,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_ts, evt_mode, evt_cols, evt_lost,
    output evt_ready
  );

endinterface

// File: rtl/trig_stretch.sv
// -----------------------------------------------------------------------------
// trig_stretch
// One retriggerable pulse stretcher. A hit loads the stretch length; otherwise
// the counter runs down to zero. The channel counts as active while nonzero.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   hit_i    : registered, masked, active-high channel hit
//   len_i    : stretch length in clocks (0 = channel never becomes active)
//   active_o : counter nonzero
// -----------------------------------------------------------------------------
module trig_stretch #(
  parameter int SW = 6
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          hit_i,
  input  logic [SW-1:0] len_i,
  output logic          active_o
);

  logic [SW-1:0] cnt_q;
  logic [SW-1:0] cnt_d;

  // Next count: reload on every hit so back-to-back hits extend the window.
  always_comb begin
    cnt_d = cnt_q;
    if (hit_i) begin
      cnt_d = len_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stretch counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign active_o = (cnt_q != '0);

endmodule

// File: rtl/coincidence_trigger_engine.sv
// -----------------------------------------------------------------------------
// coincidence_trigger_engine
// Trigger decision engine: masks and stretches NCH active-low inputs arranged as
// NLAYER layers x NCOL columns (channel i -> layer i/NCOL, column i%NCOL),
// evaluates the selected trigger mode under prescale, busy veto and deadtime,
// drives programmable-width output pulses and offers a timestamped event record.
//
// Pipeline (input sampled at edge t):
//   t   S0 inreg       t+1 S1 stretch     t+2 S2 nact/col_act/prescale
//   t+3 fire decision (dead, output counters, fire_count update)
//   t+4 trig_out high, event record loaded
//
// Ports:
//   clk_adc, rst           : clock, asynchronous active-high reset
//   coax_in, chan_mask     : raw active-low inputs, channel enables
//   coincidence_time       : stretch length in clocks
//   mode                   : 0 off, 1 any, 2 mult, 3 layer coinc, 4 rolling
//   mult_thresh, min_layers: mode 2 / mode 3 thresholds
//   busy_ok, randnum, prescale : veto and prescale (ignored in mode 4)
//   dead_time, roll_period : deadtime after a fire, rolling period
//   out_mask, out_width    : outputs to pulse on a fire, pulse length
//   trig_out, fire_count   : trigger pulses, wrapping fire counter
//   evt                    : event record channel (master side)
// -----------------------------------------------------------------------------
module coincidence_trigger_engine
  import trig_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int NLAYER = DEF_NLAYER,
  parameter int NOUT   = DEF_NOUT,
  parameter int SW     = DEF_SW,
  parameter int DTW    = DEF_DTW,
  parameter int TSW    = DEF_TSW
) (
  input  logic            clk_adc,
  input  logic            rst,
  input  logic [NCH-1:0]  coax_in,
  input  logic [NCH-1:0]  chan_mask,
  input  logic [SW-1:0]   coincidence_time,
  input  logic [2:0]      mode,
  input  logic [7:0]      mult_thresh,
  input  logic [2:0]      min_layers,
  input  logic            busy_ok,
  input  logic [31:0]     randnum,
  input  logic [31:0]     prescale,
  input  logic [DTW-1:0]  dead_time,
  input  logic [31:0]     roll_period,
  input  logic [NOUT-1:0] out_mask,
  input  logic [SW-1:0]   out_width,
  output logic [NOUT-1:0] trig_out,
  output logic [31:0]     fire_count,
  coincidence_trigger_engine_if.master evt
);

  localparam int NCOL  = NCH / NLAYER;
  localparam int NACTW = $clog2(NCH + 1);
  localparam int LW    = $clog2(NLAYER + 1);

  // ---------------------------------------------------------------- S0 / S1
  logic [NCH-1:0] inreg_q;
  logic [NCH-1:0] act_s;

  // S0: convert active-low inputs and apply the channel enables.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      inreg_q <= '0;
    end else begin
      inreg_q <= ~coax_in & chan_mask;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    trig_stretch #(.SW(SW)) u_stretch (
      .clk_i    (clk_adc),
      .rst_i    (rst),
      .hit_i    (inreg_q[i]),
      .len_i    (coincidence_time),
      .active_o (act_s[i])
    );
  end

  // ---------------------------------------------------------------- S2
  logic [NACTW-1:0] nact_d;
  logic [NACTW-1:0] nact_q;
  logic [LW-1:0]    lay_s [NCOL];
  logic [NCOL-1:0]  col_act_d;
  logic [NCOL-1:0]  col_act_q;
  logic             prescale_pass_q;

  // S2 combinational: total active count and per-column layer counts.
  always_comb begin
    nact_d = '0;
    for (int i = 0; i < NCH; i++) begin
      nact_d = nact_d + NACTW'(act_s[i]);
    end
    for (int c = 0; c < NCOL; c++) begin
      lay_s[c] = '0;
      for (int l = 0; l < NLAYER; l++) begin
        lay_s[c] = lay_s[c] + LW'(act_s[l*NCOL + c]);
      end
      col_act_d[c] = (32'(lay_s[c]) >= 32'(min_layers));
    end
  end

  // S2 registers, including the prescale decision for the same slot.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      nact_q          <= '0;
      col_act_q       <= '0;
      prescale_pass_q <= 1'b0;
    end else begin
      nact_q          <= nact_d;
      col_act_q       <= col_act_d;
      prescale_pass_q <= (randnum <= prescale);
    end
  end

  // ---------------------------------------------------------------- S3
  trig_mode_e      mode_s;
  logic [31:0]     roll_q;
  logic [31:0]     roll_d;
  logic            roll_hit_s;
  logic            cond_s;
  logic            fire_s;
  logic [DTW-1:0]  dead_q;
  logic [DTW-1:0]  dead_d;
  logic [SW-1:0]   out_cnt_q [NOUT];
  logic [SW-1:0]   out_cnt_d [NOUT];
  logic [NOUT-1:0] trig_d;
  logic [NOUT-1:0] trig_q;
  logic [31:0]     fire_count_q;
  logic [31:0]     fire_count_d;
  logic [TSW-1:0]  ts_q;

  assign mode_s = trig_mode_e'(mode);

  // Trigger condition and fire rule; rolling mode bypasses busy and prescale.
  always_comb begin
    cond_s     = 1'b0;
    // A zero period would otherwise match only after 2^32 clocks; block it.
    roll_hit_s = (roll_period != 32'd0) && (roll_q == (roll_period - 32'd1));
    case (mode_s)
      ANY:     cond_s = (nact_q != '0);
      MULT:    cond_s = ({{(32-NACTW){1'b0}}, nact_q} >= {24'd0, mult_thresh});
      COIN:    cond_s = |col_act_q;
      ROLL:    cond_s = roll_hit_s;
      default: cond_s = 1'b0;
    endcase
    fire_s = cond_s && (dead_q == '0) &&
             ((mode_s == ROLL) || (busy_ok && prescale_pass_q));
  end

  // Next state for roll counter, deadtime, output counters and fire count.
  always_comb begin
    if ((mode_s != ROLL) || roll_hit_s) begin
      roll_d = 32'd0;
    end else begin
      roll_d = roll_q + 32'd1;
    end

    if (fire_s) begin
      dead_d = dead_time;
    end else if (dead_q != '0) begin
      dead_d = dead_q - DTW'(1);
    end else begin
      dead_d = dead_q;
    end

    for (int k = 0; k < NOUT; k++) begin
      if (fire_s && out_mask[k]) begin
        out_cnt_d[k] = out_width;
      end else if (out_cnt_q[k] != '0) begin
        out_cnt_d[k] = out_cnt_q[k] - SW'(1);
      end else begin
        out_cnt_d[k] = out_cnt_q[k];
      end
      trig_d[k] = (out_cnt_q[k] != '0);
    end

    if (fire_s) begin
      fire_count_d = fire_count_q + 32'd1;
    end else begin
      fire_count_d = fire_count_q;
    end
  end

  // Decision-stage registers, output pulse registers and the timestamp.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      roll_q       <= 32'd0;
      dead_q       <= '0;
      trig_q       <= '0;
      fire_count_q <= 32'd0;
      ts_q         <= '0;
      for (int k = 0; k < NOUT; k++) begin
        out_cnt_q[k] <= '0;
      end
    end else begin
      roll_q       <= roll_d;
      dead_q       <= dead_d;
      trig_q       <= trig_d;
      fire_count_q <= fire_count_d;
      ts_q         <= ts_q + TSW'(1);
      out_cnt_q    <= out_cnt_d;
    end
  end

  assign trig_out   = trig_q;
  assign fire_count = fire_count_q;

  // ---------------------------------------------------------------- event record
  // The fire and its context are held one clock so the record appears in the
  // same cycle as the first output pulse clock.
  logic            fire_q;
  logic [TSW-1:0]  snap_ts_q;
  logic [2:0]      snap_mode_q;
  logic [NCOL-1:0] snap_cols_q;

  logic            evt_valid_q, evt_valid_d;
  logic [TSW-1:0]  evt_ts_q, evt_ts_d;
  logic [2:0]      evt_mode_q, evt_mode_d;
  logic [NCOL-1:0] evt_cols_q, evt_cols_d;
  logic [15:0]     evt_lost_q, evt_lost_d;

  // Snapshot of the decision-cycle context.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      fire_q      <= 1'b0;
      snap_ts_q   <= '0;
      snap_mode_q <= 3'd0;
      snap_cols_q <= '0;
    end else begin
      fire_q      <= fire_s;
      snap_ts_q   <= ts_q;
      snap_mode_q <= mode;
      snap_cols_q <= col_act_q;
    end
  end

  // Single-entry buffer: load when empty or drained this cycle, else count loss.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ts_d    = evt_ts_q;
    evt_mode_d  = evt_mode_q;
    evt_cols_d  = evt_cols_q;
    evt_lost_d  = evt_lost_q;
    if (fire_q) begin
      if (!evt_valid_q || evt.evt_ready) begin
        evt_valid_d = 1'b1;
        evt_ts_d    = snap_ts_q;
        evt_mode_d  = snap_mode_q;
        evt_cols_d  = snap_cols_q;
      end else begin
        evt_lost_d  = sat_inc16(evt_lost_q);
      end
    end else if (evt.evt_ready) begin
      evt_valid_d = 1'b0;
    end else begin
      evt_valid_d = evt_valid_q;
    end
  end

  // Event record registers.
  always_ff @(posedge clk_adc or posedge rst) begin
    if (rst) begin
      evt_valid_q <= 1'b0;
      evt_ts_q    <= '0;
      evt_mode_q  <= 3'd0;
      evt_cols_q  <= '0;
      evt_lost_q  <= 16'd0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_ts_q    <= evt_ts_d;
      evt_mode_q  <= evt_mode_d;
      evt_cols_q  <= evt_cols_d;
      evt_lost_q  <= evt_lost_d;
    end
  end

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_ts    = evt_ts_q;
  assign evt.evt_mode  = evt_mode_q;
  assign evt.evt_cols  = evt_cols_q;
  assign evt.evt_lost  = evt_lost_q;

endmodule

// File: tb/tb_coincidence_trigger_engine.sv
module tb_coincidence_trigger_engine;

  localparam int NCH = 64;
  localparam int NCOL = 16;
  localparam int NOUT = 16;
  localparam int TSW = 56;

  logic            clk_adc = 1'b0;
  logic            rst;
  logic [NCH-1:0]  coax_in;
  logic [NCH-1:0]  chan_mask;
  logic [5:0]      coincidence_time;
  logic [2:0]      mode;
  logic [7:0]      mult_thresh;
  logic [2:0]      min_layers;
  logic            busy_ok;
  logic [31:0]     randnum;
  logic [31:0]     prescale;
  logic [7:0]      dead_time;
  logic [31:0]     roll_period;
  logic [NOUT-1:0] out_mask;
  logic [5:0]      out_width;
  logic [NOUT-1:0] trig_out;
  logic [31:0]     fire_count;

  coincidence_trigger_engine_if #(.NCOL(NCOL), .TSW(TSW)) evt_if ();

  coincidence_trigger_engine #(
    .NCH(NCH), .NLAYER(4), .NOUT(NOUT), .SW(6), .DTW(8), .TSW(TSW)
  ) dut (
    .clk_adc(clk_adc), .rst(rst), .coax_in(coax_in), .chan_mask(chan_mask),
    .coincidence_time(coincidence_time), .mode(mode), .mult_thresh(mult_thresh),
    .min_layers(min_layers), .busy_ok(busy_ok), .randnum(randnum),
    .prescale(prescale), .dead_time(dead_time), .roll_period(roll_period),
    .out_mask(out_mask), .out_width(out_width), .trig_out(trig_out),
    .fire_count(fire_count), .evt(evt_if)
  );

  always #5 clk_adc = ~clk_adc;

  // Reference timestamp: counts clocks since reset release.
  logic [TSW-1:0] tb_ts;
  always @(posedge clk_adc or posedge rst) begin
    if (rst) tb_ts <= '0;
    else     tb_ts <= tb_ts + 56'd1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [7:0]  thr;
    logic [2:0]  ml;
    logic        busy;
    logic [31:0] pre;
    logic [31:0] rnd;
    logic [63:0] cmask;
    logic [63:0] pulse;
    logic [5:0]  ow;
    logic        exp_fire;
    logic [15:0] exp_cols;
    logic        exp_trig;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] md, input logic [7:0] thr, input logic [2:0] ml,
                              input logic busy, input logic [31:0] pre, input logic [31:0] rnd,
                              input logic [63:0] cmask, input logic [63:0] pulse, input logic [5:0] ow,
                              input logic ef, input logic [15:0] ec, input logic et);
    vec_t v;
    v.mode = md; v.thr = thr; v.ml = ml; v.busy = busy; v.pre = pre; v.rnd = rnd;
    v.cmask = cmask; v.pulse = pulse; v.ow = ow;
    v.exp_fire = ef; v.exp_cols = ec; v.exp_trig = et;
    return v;
  endfunction

  vec_t vec [14];

  task automatic apply_cfg(input vec_t v);
    mode = v.mode; mult_thresh = v.thr; min_layers = v.ml; busy_ok = v.busy;
    prescale = v.pre; randnum = v.rnd; chan_mask = v.cmask; out_width = v.ow;
    out_mask = 16'h0001; dead_time = 8'd20; coincidence_time = 6'd3;
    roll_period = 32'd0; coax_in = '1; evt_if.evt_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_adc); rst = 1'b1;
    @(negedge clk_adc); rst = 1'b0;
  endtask

  // Pull the selected channels low for one clock; returns just after that edge.
  task automatic pulse(input logic [63:0] chans);
    @(negedge clk_adc); coax_in = ~chans;
    @(negedge clk_adc); coax_in = '1;
  endtask

  task automatic fire_check(input int idx, input vec_t v);
    logic [63:0] exp_ts;
    pulse(v.pulse);
    @(negedge clk_adc);
    @(negedge clk_adc); exp_ts = 64'(tb_ts);
    @(negedge clk_adc);
    chk($sformatf("v%0d_fc_decision", idx), 64'(fire_count), 64'(v.exp_fire));
    chk($sformatf("v%0d_trig_early", idx), 64'(trig_out), 64'd0);
    @(negedge clk_adc);
    chk($sformatf("v%0d_trig0", idx), 64'(trig_out[0]), 64'(v.exp_trig));
    chk($sformatf("v%0d_evt_valid", idx), 64'(evt_if.evt_valid), 64'(v.exp_fire));
    if (v.exp_fire) begin
      chk($sformatf("v%0d_evt_mode", idx), 64'(evt_if.evt_mode), 64'(v.mode));
      chk($sformatf("v%0d_evt_cols", idx), 64'(evt_if.evt_cols), 64'(v.exp_cols));
      chk($sformatf("v%0d_evt_ts", idx), 64'(evt_if.evt_ts), exp_ts);
    end
    repeat (20) @(negedge clk_adc);
    chk($sformatf("v%0d_fc_final", idx), 64'(fire_count), 64'(v.exp_fire));
    chk($sformatf("v%0d_trig_end", idx), 64'(trig_out), 64'd0);
  endtask

  // Record loop indices at which fire_count moves over n cycles.
  task automatic watch_fires(input int n, input logic pulse_f, output int idx_q[$]);
    logic [31:0] prev;
    idx_q = {};
    prev = fire_count;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_adc);
      if (fire_count != prev) idx_q.push_back(i);
      prev = fire_count;
      if (pulse_f) coax_in = ((i % 3) == 0) ? ~64'hF : '1;
    end
    coax_in = '1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fires[$];
    int cnt, first, other;
    logic [31:0] fc_a;
    localparam logic [31:0] PMAX = 32'hFFFF_FFFF;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    vec[0]  = mk(3'd1, 8'd0,  3'd3, 1'b1, PMAX,  32'd0, ALL, 64'h8, 6'd16, 1'b1, 16'h0000, 1'b1);
    vec[1]  = mk(3'd3, 8'd0,  3'd3, 1'b1, PMAX,  32'd0, ALL, 64'h0000_0004_0004_0004, 6'd16, 1'b1, 16'h0004, 1'b1);
    vec[2]  = mk(3'd3, 8'd0,  3'd3, 1'b1, PMAX,  32'd0, ALL, 64'h0000_0000_0004_0004, 6'd16, 1'b0, 16'h0000, 1'b0);
    vec[3]  = mk(3'd3, 8'd0,  3'd4, 1'b1, PMAX,  32'd0, ALL, 64'h0020_0020_0020_0020, 6'd16, 1'b1, 16'h0020, 1'b1);
    vec[4]  = mk(3'd2, 8'd4,  3'd3, 1'b1, PMAX,  32'd0, ALL, 64'hF, 6'd16, 1'b1, 16'h0000, 1'b1);
    vec[5]  = mk(3'd2, 8'd4,  3'd3, 1'b1, PMAX,  32'd0, ALL, 64'h7, 6'd16, 1'b0, 16'h0000, 1'b0);
    vec[6]  = mk(3'd1, 8'd0,  3'd3, 1'b0, PMAX,  32'd0, ALL, 64'h8, 6'd16, 1'b0, 16'h0000, 1'b0);
    vec[7]  = mk(3'd1, 8'd0,  3'd3, 1'b1, 32'd0, 32'd5, ALL, 64'h8, 6'd16, 1'b0, 16'h0000, 1'b0);
    vec[8]  = mk(3'd1, 8'd0,  3'd3, 1'b1, 32'd5, 32'd5, ALL, 64'h8, 6'd16, 1'b1, 16'h0000, 1'b1);
    vec[9]  = mk(3'd0, 8'd0,  3'd3, 1'b1, PMAX,  32'd0, ALL, 64'h8, 6'd16, 1'b0, 16'h0000, 1'b0);
    vec[10] = mk(3'd6, 8'd0,  3'd3, 1'b1, PMAX,  32'd0, ALL, 64'h8, 6'd16, 1'b0, 16'h0000, 1'b0);
    vec[11] = mk(3'd1, 8'd0,  3'd3, 1'b1, PMAX,  32'd0, ~64'h8, 64'h8, 6'd16, 1'b0, 16'h0000, 1'b0);
    vec[12] = mk(3'd1, 8'd0,  3'd3, 1'b1, PMAX,  32'd0, ALL, 64'h8, 6'd0, 1'b1, 16'h0000, 1'b0);
    vec[13] = mk(3'd2, 8'd64, 3'd3, 1'b1, PMAX,  32'd0, ALL, ALL, 6'd16, 1'b1, 16'hFFFF, 1'b1);

    rst = 1'b1;
    apply_cfg(vec[0]);
    repeat (2) @(negedge clk_adc);
    chk("reset_trig", 64'(trig_out), 64'd0);
    chk("reset_fc", 64'(fire_count), 64'd0);
    chk("reset_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("reset_lost", 64'(evt_if.evt_lost), 64'd0);
    chk("reset_ts", 64'(evt_if.evt_ts), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apply_cfg(vec[i]);
      do_reset();
      fire_check(i, vec[i]);
    end

    // Pulse shape: 16 cycles, starting 4 clocks after the input is sampled.
    apply_cfg(vec[0]);
    do_reset();
    pulse(64'h8);
    cnt = 0; first = -1; other = 0;
    for (int k = 2; k <= 30; k++) begin
      @(negedge clk_adc);
      if (trig_out[0]) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (trig_out[15:1] != 15'd0) other = 1;
    end
    chk("width_count", 64'(cnt), 64'd16);
    chk("width_start", 64'(first), 64'd5);
    chk("width_unmasked", 64'(other), 64'd0);

    // Deadtime: continuous multiplicity condition, fires 11 cycles apart.
    apply_cfg(vec[4]);
    dead_time = 8'd10; coincidence_time = 6'd5;
    do_reset();
    watch_fires(60, 1'b1, fires);
    chk("dt_nfires_ge3", 64'(fires.size() >= 3), 64'd1);
    for (int j = 1; j < fires.size(); j++)
      chk($sformatf("dt_gap%0d", j), 64'(fires[j] - fires[j-1]), 64'd11);

    // Rolling mode ignores busy and prescale.
    apply_cfg(vec[0]);
    mode = 3'd4; busy_ok = 1'b0; prescale = 32'd0; randnum = 32'd5;
    dead_time = 8'd0; roll_period = 32'd100;
    do_reset();
    watch_fires(350, 1'b0, fires);
    chk("roll_nfires_ge3", 64'(fires.size() >= 3), 64'd1);
    for (int j = 1; j < fires.size(); j++)
      chk($sformatf("roll_gap%0d", j), 64'(fires[j] - fires[j-1]), 64'd100);

    roll_period = 32'd0;
    do_reset();
    repeat (250) @(negedge clk_adc);
    chk("roll_zero_period", 64'(fire_count), 64'd0);

    roll_period = 32'd1;
    do_reset();
    @(negedge clk_adc); fc_a = fire_count;
    repeat (10) @(negedge clk_adc);
    chk("roll_period1_rate", 64'(fire_count - fc_a), 64'd10);

    // Event buffer: full buffer keeps first record and counts losses.
    apply_cfg(vec[0]);
    dead_time = 8'd0; coincidence_time = 6'd1;
    do_reset();
    pulse(64'h8); repeat (8) @(negedge clk_adc);
    mode = 3'd2; mult_thresh = 8'd1;
    pulse(64'h8); repeat (8) @(negedge clk_adc);
    pulse(64'h8); repeat (8) @(negedge clk_adc);
    chk("buf_fc", 64'(fire_count), 64'd3);
    chk("buf_valid", 64'(evt_if.evt_valid), 64'd1);
    chk("buf_mode_kept", 64'(evt_if.evt_mode), 64'd1);
    chk("buf_lost", 64'(evt_if.evt_lost), 64'd2);
    pulse(64'h8);
    repeat (3) @(negedge clk_adc);
    evt_if.evt_ready = 1'b1;
    @(negedge clk_adc);
    evt_if.evt_ready = 1'b0;
    chk("coinc_valid", 64'(evt_if.evt_valid), 64'd1);
    chk("coinc_mode_new", 64'(evt_if.evt_mode), 64'd2);
    chk("coinc_lost", 64'(evt_if.evt_lost), 64'd2);
    repeat (4) @(negedge clk_adc);
    evt_if.evt_ready = 1'b1;
    @(negedge clk_adc);
    evt_if.evt_ready = 1'b0;
    chk("drain_valid", 64'(evt_if.evt_valid), 64'd0);

    // Reset mid-pulse clears everything at once; timestamp restarts.
    apply_cfg(vec[0]);
    do_reset();
    pulse(64'h8);
    repeat (5) @(negedge clk_adc);
    chk("midrst_pulse_on", 64'(trig_out[0]), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_trig", 64'(trig_out), 64'd0);
    chk("midrst_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("midrst_fc", 64'(fire_count), 64'd0);
    chk("midrst_ts", 64'(evt_if.evt_ts), 64'd0);
    @(negedge clk_adc); rst = 1'b0;
    fire_check(100, vec[0]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
